// File: rtl/bist_stuck_detector.sv
// Stuck-at channel detector: observes a channel bundle for a fixed window of test cases, then
// streams the index and kind (stuck-low / stuck-high) of every channel that never toggled.
module bist_stuck_detector #(
  parameter int TEST_CHANNELS = 70,
  parameter int TEST_CASES    = 1000,
  parameter int SKIP_CYCLES   = 0,
  localparam int CH_W  = (TEST_CHANNELS > 1) ? $clog2(TEST_CHANNELS) : 1,
  localparam int CNT_W = $clog2(TEST_CHANNELS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  output logic                     busy,
  output logic                     failed,
  output logic                     fault_valid,
  input  logic                     fault_ready,
  output logic [CH_W-1:0]          fault_channel,
  output logic [1:0]               fault_kind,
  output logic [CNT_W-1:0]         fault_count
);

  localparam int CYC_MAX = (SKIP_CYCLES > TEST_CASES) ? SKIP_CYCLES : TEST_CASES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0]         SKIP_LAST = CYC_W'(SKIP_CYCLES - 1);
  localparam logic [CYC_W-1:0]         CASE_LAST = CYC_W'(TEST_CASES - 1);
  localparam logic [CNT_W-1:0]         SCAN_END  = CNT_W'(TEST_CHANNELS);
  localparam logic [TEST_CHANNELS-1:0] ONE_HOT0  = TEST_CHANNELS'(1);

  if (TEST_CASES < 1) begin : g_bad_cases
    $error("bist_stuck_detector: TEST_CASES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_SKIP,
    S_OBSERVE,
    S_REPORT,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [CYC_W-1:0]         r_cycle;
  logic [CNT_W-1:0]         r_scanCh;
  logic [TEST_CHANNELS-1:0] r_seenHi;
  logic [TEST_CHANNELS-1:0] r_seenLo;
  logic                     r_busy;
  logic                     r_failed;
  logic                     r_faultValid;
  logic [CH_W-1:0]          r_faultChannel;
  logic [1:0]               r_faultKind;
  logic [CNT_W-1:0]         r_faultCount;

  logic [TEST_CHANNELS-1:0] w_chSel;
  logic [TEST_CHANNELS-1:0] w_faultMask;
  logic                     w_curFaulty;
  logic                     w_curHi;
  logic                     w_xfer;
  logic                     w_slotFree;
  logic                     w_scanDone;
  logic [CNT_W-1:0]         w_countNext;

  // r_scanCh points at the next channel to examine; it equals TEST_CHANNELS once all are scanned.
  assign w_chSel     = ONE_HOT0 << r_scanCh;
  assign w_faultMask = ~(r_seenHi & r_seenLo);
  assign w_curFaulty = |(w_faultMask & w_chSel);
  assign w_curHi     = |(r_seenHi & w_chSel);
  assign w_xfer      = r_faultValid & fault_ready;
  assign w_slotFree  = ~r_faultValid | fault_ready;
  assign w_scanDone  = (r_scanCh == SCAN_END);
  assign w_countNext = r_faultCount + CNT_W'(w_xfer);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= (SKIP_CYCLES == 0) ? S_OBSERVE : S_SKIP;
      r_cycle        <= '0;
      r_scanCh       <= '0;
      r_seenHi       <= '0;
      r_seenLo       <= '0;
      r_busy         <= 1'b1;
      r_failed       <= 1'b0;
      r_faultValid   <= 1'b0;
      r_faultChannel <= '0;
      r_faultKind    <= 2'b00;
      r_faultCount   <= '0;
    end else begin
      unique case (r_state)
        S_SKIP: begin
          if (r_cycle == SKIP_LAST) begin
            r_cycle <= '0;
            r_state <= S_OBSERVE;
          end else begin
            r_cycle <= r_cycle + CYC_W'(1);
          end
        end

        S_OBSERVE: begin
          r_seenHi <= r_seenHi | input_channels;
          r_seenLo <= r_seenLo | ~input_channels;
          if (r_cycle == CASE_LAST) begin
            r_cycle  <= '0;
            r_scanCh <= '0;
            r_state  <= S_REPORT;
          end else begin
            r_cycle <= r_cycle + CYC_W'(1);
          end
        end

        // A transfer and the scan of the next channel share a cycle, so with ready held high
        // every channel costs exactly one cycle whether or not it is faulty.
        S_REPORT: begin
          r_faultCount <= w_countNext;
          if (w_slotFree) begin
            if (w_scanDone) begin
              r_faultValid <= 1'b0;
              r_busy       <= 1'b0;
              r_failed     <= (w_countNext != '0);
              r_state      <= S_DONE;
            end else begin
              r_scanCh <= r_scanCh + CNT_W'(1);
              if (w_curFaulty) begin
                r_faultValid   <= 1'b1;
                r_faultChannel <= r_scanCh[CH_W-1:0];
                r_faultKind    <= w_curHi ? 2'b10 : 2'b01;
              end else begin
                r_faultValid <= 1'b0;
              end
            end
          end
        end

        S_DONE: begin
          r_state <= S_DONE;
        end

        default: begin
          r_state <= S_DONE;
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign failed        = r_failed;
  assign fault_valid   = r_faultValid;
  assign fault_channel = r_faultChannel;
  assign fault_kind    = r_faultKind;
  assign fault_count   = r_faultCount;

endmodule
